dcache_direct_mapped: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the ALU result (used as the load/store address) and the backing data memory. It serves load hits combinationally in the same cycle and stalls the core on misses and on all stores. It refills 4-word lines through a single-beat req/ack memory handshake.

---
 rtl/dcache_direct_mapped.sv | 149 ++++++++++++++
 tb/tb_dcache_direct_mapped.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Load hits are served combinationally; misses refill over a single-beat req/ack port.
module dcache_direct_mapped #(
   parameter int BUS_WIDTH  = 32,
   parameter int INDEX_BITS = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [BUS_WIDTH-1:0] i_Addr,
   input  logic [BUS_WIDTH-1:0] i_WriteData,
   input  logic                 i_MemRead,
   input  logic                 i_MemWrite,
   output logic [BUS_WIDTH-1:0] o_ReadData,
   output logic                 o_Stall,
   output logic                 o_MemReq,
   output logic                 o_MemWe,
   output logic [BUS_WIDTH-1:0] o_MemAddr,
   output logic [BUS_WIDTH-1:0] o_MemWData,
   input  logic                 i_MemAck,
   input  logic [BUS_WIDTH-1:0] i_MemRData
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = BUS_WIDTH - INDEX_BITS - 4;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

   state_t                 state;
   logic [1:0]             beat_cnt;
   logic                   settle;
   logic [LINES-1:0]       valid;
   logic [TAG_W-1:0]       tag_mem  [LINES];
   logic [BUS_WIDTH-1:0]   data_mem [LINES][4];

   logic [1:0]             addr_offset;
   logic [INDEX_BITS-1:0]  addr_index;
   logic [TAG_W-1:0]       addr_tag;
   logic                   hit;
   logic                   is_store;
   logic                   is_load;
   logic                   mem_ack;
   logic                   addr_lo_unused;

   assign addr_offset    = i_Addr[3:2];
   assign addr_index     = i_Addr[INDEX_BITS+3:4];
   assign addr_tag       = i_Addr[BUS_WIDTH-1:INDEX_BITS+4];
   assign addr_lo_unused = ^i_Addr[1:0];

   assign hit      = valid[addr_index] && (tag_mem[addr_index] == addr_tag);
   assign is_store = i_MemWrite;
   assign is_load  = i_MemRead & ~i_MemWrite;
   assign mem_ack  = i_MemAck & o_MemReq;

   // Control state: only this block sees reset; line payload below is never cleared.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         valid    <= '0;
         beat_cnt <= 2'd0;
         settle   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               settle <= 1'b0;
               if (!settle) begin
                  if (is_store) begin
                     state <= WRITE;
                  end else if (is_load && !hit) begin
                     state    <= REFILL;
                     beat_cnt <= 2'd0;
                  end
               end
            end
            REFILL: begin
               if (mem_ack) begin
                  beat_cnt <= beat_cnt + 2'd1;
                  if (beat_cnt == 2'd3) begin
                     valid[addr_index] <= 1'b1;
                     settle            <= 1'b1;
                     state             <= IDLE;
                  end
               end
            end
            WRITE: begin
               if (mem_ack) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && mem_ack) begin
         if (state == REFILL) begin
            data_mem[addr_index][beat_cnt] <= i_MemRData;
            if (beat_cnt == 2'd3) begin
               tag_mem[addr_index] <= addr_tag;
            end
         end else if (state == WRITE && hit) begin
            data_mem[addr_index][addr_offset] <= i_WriteData;
         end
      end
   end

   // The cycle after a refill holds the stall once more before the held load is served.
   always_comb begin
      o_ReadData = '0;
      o_Stall    = 1'b0;
      o_MemReq   = 1'b0;
      o_MemWe    = 1'b0;
      o_MemAddr  = '0;
      o_MemWData = '0;
      case (state)
         IDLE: begin
            if (settle) begin
               o_Stall = 1'b1;
            end else if (is_store) begin
               o_Stall = 1'b1;
            end else if (is_load) begin
               if (hit) begin
                  o_ReadData = data_mem[addr_index][addr_offset];
               end else begin
                  o_Stall = 1'b1;
               end
            end
         end
         REFILL: begin
            o_Stall   = 1'b1;
            o_MemReq  = 1'b1;
            o_MemAddr = {i_Addr[BUS_WIDTH-1:4], beat_cnt, 2'b00};
         end
         WRITE: begin
            o_Stall    = 1'b1;
            o_MemReq   = 1'b1;
            o_MemWe    = 1'b1;
            o_MemAddr  = {i_Addr[BUS_WIDTH-1:2], 2'b00};
            o_MemWData = i_WriteData;
         end
         DONE: begin
            o_Stall = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Bench for dcache_direct_mapped: directed vector table, reset-mid-refill sequence,
// then random accesses checked against a line-residency model over a backing memory.
module tb_dcache_direct_mapped;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr_in;
   logic [31:0] wdata_in;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] read_data;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   dcache_direct_mapped #(.BUS_WIDTH(32), .INDEX_BITS(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_Addr(addr_in), .i_WriteData(wdata_in),
      .i_MemRead(mem_read), .i_MemWrite(mem_write), .o_ReadData(read_data),
      .o_Stall(stall), .o_MemReq(mem_req), .o_MemWe(mem_we), .o_MemAddr(mem_addr),
      .o_MemWData(mem_wdata), .i_MemAck(mem_ack), .i_MemRData(mem_rdata)
   );

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } beat_t;

   beat_t       beats[$];
   logic [31:0] mem [logic [31:0]];
   int          cur_wait = 0;
   int          wcnt = 0;
   logic        force_ack = 1'b0;
   int          model_line [16];

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return dflt(a);
   endfunction

   // Backing memory: acks after cur_wait idle cycles of a held request.
   always @(negedge clk) begin
      if (force_ack) begin
         mem_ack   = 1'b1;
         mem_rdata = 32'hBAD0_BAD0;
      end else if (rst || !mem_req) begin
         mem_ack = 1'b0;
         wcnt    = 0;
      end else if (wcnt >= cur_wait) begin
         mem_ack = 1'b1;
         wcnt    = 0;
         if (mem_we) mem[mem_addr] = mem_wdata;
         mem_rdata = mem_rd(mem_addr);
         beats.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
      end else begin
         mem_ack = 1'b0;
         wcnt++;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // op: 0 = load, 1 = store, 2 = both strobes (store)
   task automatic run_access(input int op, input logic [31:0] a, input logic [31:0] wd,
                             input int wt, input logic [31:0] exp_rd, input int exp_stall,
                             input int exp_beats, input string nm);
      int cnt;
      int bad;
      beats.delete();
      cur_wait  = wt;
      mem_read  = (op != 1);
      mem_write = (op != 0);
      addr_in   = a;
      wdata_in  = wd;
      cnt = 0;
      @(negedge clk);
      while (stall && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      check({nm, "_stall_cycles"}, 32'(cnt), 32'(exp_stall));
      check({nm, "_rdata"}, read_data, (op == 0) ? exp_rd : 32'h0);
      check({nm, "_req_low"}, {31'h0, mem_req}, 32'h0);
      @(posedge clk);
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      check({nm, "_beat_count"}, 32'(beats.size()), 32'(exp_beats));
      bad = 0;
      for (int i = 0; i < beats.size(); i++) begin
         if (op == 0) begin
            if (beats[i].we !== 1'b0 || beats[i].addr !== ((a & ~32'hF) + 32'(4 * i))) bad++;
         end else begin
            if (beats[i].we !== 1'b1 || beats[i].addr !== (a & ~32'h3) ||
                beats[i].wdata !== wd) bad++;
         end
      end
      check({nm, "_beat_content"}, 32'(bad), 32'h0);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) model_line[i] = -1;
   endfunction

   function automatic void model_update(input int op, input logic [31:0] a);
      if (op == 0) model_line[a[7:4]] = int'(a >> 4);
   endfunction

   task automatic model_access(input int op, input logic [31:0] a, input logic [31:0] wd,
                               input int wt, input string nm);
      logic hit;
      hit = (model_line[a[7:4]] == int'(a >> 4));
      if (op != 0)
         run_access(op, a, wd, wt, 32'h0, 1 + (wt + 1), 1, nm);
      else if (hit)
         run_access(op, a, wd, wt, mem_rd(a & ~32'h3), 0, 0, nm);
      else
         run_access(op, a, wd, wt, mem_rd(a & ~32'h3), 1 + 4 * (wt + 1) + 1, 4, nm);
      model_update(op, a);
   endtask

   typedef struct {
      int          op;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          wt;
      logic [31:0] exp_rd;
      int          exp_stall;
      int          exp_beats;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{0, 32'h40,   32'h0,         1, 32'h11,         10, 4};
      vecs[1] = '{0, 32'h44,   32'h0,         1, 32'h22,          0, 0};
      vecs[2] = '{0, 32'h440,  32'h0,         1, dflt(32'h440),  10, 4};
      vecs[3] = '{0, 32'h40,   32'h0,         0, 32'h11,          6, 4};
      vecs[4] = '{1, 32'h48,   32'hDEADBEEF,  1, 32'h0,           3, 1};
      vecs[5] = '{0, 32'h48,   32'h0,         1, 32'hDEADBEEF,    0, 0};
      vecs[6] = '{1, 32'h1000, 32'hCAFEF00D,  0, 32'h0,           2, 1};
      vecs[7] = '{0, 32'h1000, 32'h0,         0, 32'hCAFEF00D,    6, 4};
      vecs[8] = '{2, 32'h40,   32'h12345678,  1, 32'h0,           3, 1};
      vecs[9] = '{0, 32'h40,   32'h0,         1, 32'h12345678,    0, 0};

      mem[32'h40] = 32'h11;
      mem[32'h44] = 32'h22;
      mem[32'h48] = 32'h33;
      mem[32'h4C] = 32'h44;
      mem_ack = 1'b0; mem_rdata = '0;
      addr_in = '0; wdata_in = '0; mem_read = 1'b0; mem_write = 1'b0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_stall", {31'h0, stall}, 32'h0);
      check("rst_req", {31'h0, mem_req}, 32'h0);
      check("rst_we", {31'h0, mem_we}, 32'h0);
      check("rst_maddr", mem_addr, 32'h0);
      check("rst_mwdata", mem_wdata, 32'h0);
      check("rst_rdata", read_data, 32'h0);
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         run_access(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].wt, vecs[i].exp_rd,
                    vecs[i].exp_stall, vecs[i].exp_beats, $sformatf("vec%0d", i));
         model_update(vecs[i].op, vecs[i].addr);
      end

      // Reset in the middle of a refill, after two acks have landed.
      begin
         int n;
         beats.delete();
         cur_wait  = 1;
         addr_in   = 32'h80;
         mem_read  = 1'b1;
         mem_write = 1'b0;
         n = 0;
         while (beats.size() < 2 && n < 50) begin
            @(posedge clk);
            n++;
         end
         check("midrst_two_acks", 32'(beats.size()), 32'd2);
         #1 rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
         mem_read  = 1'b0;
         force_ack = 1'b1;
         @(negedge clk);
         check("midrst_req", {31'h0, mem_req}, 32'h0);
         check("midrst_stall", {31'h0, stall}, 32'h0);
         check("midrst_rdata", read_data, 32'h0);
         @(posedge clk);
         #1 force_ack = 1'b0;
         model_reset();
      end
      run_access(0, 32'h80, 32'h0, 1, dflt(32'h80), 10, 4, "post_rst_80");
      model_update(0, 32'h80);
      model_access(0, 32'h44, 32'h0, 0, "post_rst_44");
      model_access(0, 32'h4C, 32'h0, 0, "post_rst_4c_hit");

      for (int i = 0; i < 40; i++) begin
         int          op;
         logic [31:0] a;
         op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         a  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
              32'($urandom_range(0, 15));
         model_access(op, a, $urandom, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
